// File: rtl/mpsk_pkg.sv
// Shared types and helpers for the M-PSK modulator.
package mpsk_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } mpsk_state_e;

  // Symbols are at most 4 bits; narrower symbols are zero-extended.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [15:0] phase_offset(
    input logic [3:0]  idx,
    input int unsigned shift
  );
    return 16'(idx) << shift;
  endfunction

endpackage

// File: rtl/mpsk_bit_assembler.sv
// Serial-to-symbol assembler with a one-deep pending register.
module mpsk_bit_assembler #(
  parameter int BITS_PER_SYM = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  input  logic                    consume,
  output logic [BITS_PER_SYM-1:0] pend_sym,
  output logic                    pend_valid
);

  localparam logic [2:0] LAST = 3'(BITS_PER_SYM - 1);

  logic [BITS_PER_SYM-1:0] shift_q, shift_d;
  logic [BITS_PER_SYM-1:0] pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [BITS_PER_SYM:0]   sh_ext;
  logic                    accept;

  assign bit_ready  = !pend_valid_q || (cnt_q < LAST);
  assign accept     = bit_valid && bit_ready;
  assign sh_ext     = {shift_q, bit_in};
  assign pend_sym   = pend_q;
  assign pend_valid = pend_valid_q;

  always_comb begin
    shift_d      = shift_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = cnt_q;
    if (consume) begin
      pend_valid_d = 1'b0;
    end
    if (accept) begin
      shift_d = sh_ext[BITS_PER_SYM-1:0];
      if (cnt_q == LAST) begin
        pend_d       = sh_ext[BITS_PER_SYM-1:0];
        pend_valid_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: rtl/mpsk_modulator.sv
// M-PSK modulator: symbol FSM, carrier NCO, mapper and output registers.
module mpsk_modulator
  import mpsk_pkg::*;
#(
  parameter int BITS_PER_SYM    = 2,
  parameter int PHASE_W         = 8,
  parameter int SAMPLES_PER_SYM = 16,
  parameter int GRAY            = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic [PHASE_W-1:0]      phase_out,
  output logic                    wave_out,
  output logic [BITS_PER_SYM-1:0] sym_out,
  output logic                    sym_strobe,
  output logic                    underrun,
  output logic                    busy
);

  localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES_PER_SYM - 1);

  mpsk_state_e             state_q, state_d;
  logic [PHASE_W-1:0]      acc_q, acc_d;
  logic [BITS_PER_SYM-1:0] sym_q, sym_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [BITS_PER_SYM-1:0] symo_q, symo_d;
  logic                    stb_q, stb_d;
  logic                    und_q, und_d;
  logic                    busy_q, busy_d;

  logic                    consume;
  logic [BITS_PER_SYM-1:0] pend_sym;
  logic                    pend_valid;
  logic [3:0]              idx;
  logic [PHASE_W-1:0]      sym_phase;

  mpsk_bit_assembler #(
    .BITS_PER_SYM(BITS_PER_SYM)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .consume   (consume),
    .pend_sym  (pend_sym),
    .pend_valid(pend_valid)
  );

  assign idx       = (GRAY != 0) ? gray2bin(4'(sym_q)) : 4'(sym_q);
  assign sym_phase = PHASE_W'(phase_offset(idx, PHASE_W - BITS_PER_SYM));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    phase_d = '0;
    symo_d  = '0;
    stb_d   = 1'b0;
    und_d   = 1'b0;
    busy_d  = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        if (enable && pend_valid) begin
          consume = 1'b1;
          sym_d   = pend_sym;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_q + freq_word;
        phase_d = acc_q + sym_phase;
        symo_d  = sym_q;
        stb_d   = (cnt_q == '0);
        busy_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          if (pend_valid && enable) begin
            consume = 1'b1;
            sym_d   = pend_sym;
            cnt_d   = '0;
          end else begin
            // Underrun only when data ran dry, not on a deliberate stop.
            und_d   = !pend_valid;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sym_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      symo_q  <= '0;
      stb_q   <= 1'b0;
      und_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      symo_q  <= symo_d;
      stb_q   <= stb_d;
      und_q   <= und_d;
      busy_q  <= busy_d;
    end
  end

  assign phase_out  = phase_q;
  assign wave_out   = phase_q[PHASE_W-1];
  assign sym_out    = symo_q;
  assign sym_strobe = stb_q;
  assign underrun   = und_q;
  assign busy       = busy_q;

endmodule
